// File: rtl/jtag_sequencer.sv
// JTAG sequencer: drains out_seq words into TCK/TMS/TDI shifts, pushes TDO bytes to in_seq.
// Build option: define JTAG_TDO_SYNC_EN to add a 2-flop TDO synchronizer (needs TCK_DIV>=3).
module jtag_sequencer #(
  parameter int TCK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seq_rst,
  input  logic       out_seq_empty,
  input  logic [4:0] out_seq_command,
  input  logic [2:0] out_seq_bits,
  input  logic [7:0] out_seq_read,
  input  logic [7:0] out_seq_tdi,
  input  logic [7:0] out_seq_tms,
  output logic       out_seq_re,
  input  logic       in_seq_full,
  output logic       in_seq_we,
  output logic [7:0] in_seq_tdo,
  output logic       in_seq_flushed,
  output logic       busy,
  output logic       TCK,
  output logic       TMS,
  output logic       TDI,
  input  logic       TDO
);

  localparam logic [4:0] CMD_WR    = 5'd1;
  localparam logic [4:0] CMD_FLUSH = 5'd2;

  localparam logic [7:0] DIV_LAST = 8'(TCK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_PUSH
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic       r_tck;
  logic       r_tms;
  logic       r_tdi;
  logic       r_flushed;
  logic [7:0] r_div;
  logic [2:0] r_idx;
  logic [2:0] r_last;
  logic       r_rd;
  logic [7:0] r_tms_w;
  logic [7:0] r_tdi_w;
  logic [7:0] r_cap;

  logic       w_pop;
  logic       w_we;
  logic       w_is_wr;
  logic       w_is_fl;
  logic       w_div_end;
  logic       w_bit_end;
  logic [2:0] w_idx_nx;
  logic       w_cap_en;
  logic       w_tdo;

  assign w_is_wr   = (out_seq_command == CMD_WR);
  assign w_is_fl   = (out_seq_command == CMD_FLUSH);
  assign w_div_end = (r_div == DIV_LAST);
  assign w_bit_end = (r_idx == r_last);
  assign w_idx_nx  = r_idx + 3'd1;

`ifdef JTAG_TDO_SYNC_EN
  logic [1:0] r_tdo_s;

  if (TCK_DIV < 3) begin : g_cfg_err
    $error("jtag_sequencer: TCK_DIV must be >= 3 with TDO sync");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tdo_s <= 2'b00;
    end else begin
      r_tdo_s <= {r_tdo_s[0], TDO};
    end
  end

  // synchronized TDO settles late, so sample at the end of HIGH
  assign w_tdo    = r_tdo_s[1];
  assign w_cap_en = (r_state == S_HIGH) && w_div_end;
`else
  assign w_tdo    = TDO;
  assign w_cap_en = (r_state == S_HIGH) && (r_div == 8'd0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt = r_state;
    w_pop = 1'b0;
    w_we  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!out_seq_empty) begin
          w_pop = 1'b1;
          if (w_is_wr) w_nxt = S_LOW;
        end
      end
      S_LOW: begin
        if (w_div_end) w_nxt = S_HIGH;
      end
      S_HIGH: begin
        if (w_div_end) begin
          if (!w_bit_end) w_nxt = S_LOW;
          else if (r_rd)  w_nxt = S_PUSH;
          else            w_nxt = S_IDLE;
        end
      end
      S_PUSH: begin
        if (!in_seq_full) begin
          w_we  = 1'b1;
          w_nxt = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
    // abort wins over everything, including a pending pop or push
    if (seq_rst) begin
      w_nxt = S_IDLE;
      w_pop = 1'b0;
      w_we  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tck     <= 1'b0;
      r_tms     <= 1'b1;
      r_tdi     <= 1'b0;
      r_flushed <= 1'b0;
      r_div     <= 8'd0;
      r_idx     <= 3'd0;
      r_last    <= 3'd0;
      r_rd      <= 1'b0;
      r_tms_w   <= 8'd0;
      r_tdi_w   <= 8'd0;
      r_cap     <= 8'd0;
    end else if (seq_rst) begin
      r_tck     <= 1'b0;
      r_tms     <= 1'b1;
      r_tdi     <= 1'b0;
      r_flushed <= 1'b0;
      r_div     <= 8'd0;
      r_idx     <= 3'd0;
      r_last    <= 3'd0;
      r_rd      <= 1'b0;
      r_tms_w   <= 8'd0;
      r_tdi_w   <= 8'd0;
      r_cap     <= 8'd0;
    end else begin
      r_tck <= (w_nxt == S_HIGH);
      if (r_state == S_LOW || r_state == S_HIGH) begin
        r_div <= w_div_end ? 8'd0 : r_div + 8'd1;
      end else begin
        r_div <= 8'd0;
      end
      if (w_pop && w_is_wr) begin
        // bits==0 wraps to 7, i.e. an 8-bit word
        r_last    <= out_seq_bits - 3'd1;
        r_rd      <= |out_seq_read;
        r_tms_w   <= out_seq_tms;
        r_tdi_w   <= out_seq_tdi;
        r_tms     <= out_seq_tms[0];
        r_tdi     <= out_seq_tdi[0];
        r_idx     <= 3'd0;
        r_cap     <= 8'd0;
        r_flushed <= 1'b0;
      end
      if (w_pop && w_is_fl) begin
        r_flushed <= 1'b1;
      end
      if (w_cap_en) begin
        r_cap[r_idx] <= w_tdo;
      end
      if (r_state == S_HIGH && w_div_end && !w_bit_end) begin
        r_idx <= w_idx_nx;
        r_tms <= r_tms_w[w_idx_nx];
        r_tdi <= r_tdi_w[w_idx_nx];
      end
    end
  end

  assign out_seq_re     = w_pop & rst_n;
  assign in_seq_we      = w_we;
  assign in_seq_tdo     = r_cap;
  assign in_seq_flushed = r_flushed;
  assign busy           = (r_state != S_IDLE);
  assign TCK            = r_tck;
  assign TMS            = r_tms;
  assign TDI            = r_tdi;

endmodule

// File: tb/tb_jtag_sequencer.sv
// Bench for jtag_sequencer: FWFT FIFO model in front, scoreboard of TDO bytes behind.
module tb_jtag_sequencer;

  localparam int TCK_DIV = 4;

  localparam logic [4:0] CMD_WR        = 5'd1;
  localparam logic [4:0] CMD_FLUSH     = 5'd2;
  localparam logic [4:0] CMD_EXECUTE   = 5'd3;
  localparam logic [4:0] CMD_STORE_SEQ = 5'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       seq_rst = 1'b0;
  logic       in_seq_full = 1'b0;
  logic       tdo_tie = 1'b0;
  logic       tdo_val = 1'b0;
  logic       out_seq_empty;
  logic [31:0] head;
  logic [4:0] s_cmd;
  logic [2:0] s_bits;
  logic [7:0] s_read;
  logic [7:0] s_tdi;
  logic [7:0] s_tms;
  logic       out_seq_re;
  logic       in_seq_we;
  logic [7:0] in_seq_tdo;
  logic       in_seq_flushed;
  logic       busy;
  logic       TCK;
  logic       TMS;
  logic       TDI;
  logic       TDO;

  assign {s_cmd, s_bits, s_read, s_tdi, s_tms} = head;
  assign TDO = tdo_tie ? TDI : tdo_val;

  jtag_sequencer #(.TCK_DIV(TCK_DIV)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .seq_rst        (seq_rst),
    .out_seq_empty  (out_seq_empty),
    .out_seq_command(s_cmd),
    .out_seq_bits   (s_bits),
    .out_seq_read   (s_read),
    .out_seq_tdi    (s_tdi),
    .out_seq_tms    (s_tms),
    .out_seq_re     (out_seq_re),
    .in_seq_full    (in_seq_full),
    .in_seq_we      (in_seq_we),
    .in_seq_tdo     (in_seq_tdo),
    .in_seq_flushed (in_seq_flushed),
    .busy           (busy),
    .TCK            (TCK),
    .TMS            (TMS),
    .TDI            (TDI),
    .TDO            (TDO)
  );

  always #5 clk = ~clk;

  logic [31:0] fifo_q[$];
  logic [7:0]  exp_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int pops = 0;
  int pushes = 0;
  int pulses = 0;
  int pop_cyc = 0;
  int we_cyc = 0;
  int flpop_cyc = 0;
  int fl_cyc = 0;
  logic [7:0] tms_acc = 8'd0;
  logic [7:0] tdi_acc = 8'd0;
  logic prev_tck = 1'b0;
  logic prev_fl = 1'b0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic refresh();
    out_seq_empty = (fifo_q.size() == 0);
    head = out_seq_empty ? 32'd0 : fifo_q[0];
  endtask

  task automatic send(logic [4:0] c, logic [2:0] b, logic [7:0] r,
                      logic [7:0] di, logic [7:0] ms);
    fifo_q.push_back({c, b, r, di, ms});
    refresh();
  endtask

  task automatic wait_idle(int max);
    int n = 0;
    while ((fifo_q.size() != 0 || busy) && n < max) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n >= max), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_pulses(int target, int max);
    int n = 0;
    while (pulses < target && n < max) begin
      @(negedge clk);
      n++;
    end
    check("pulse_timeout", 32'(n >= max), 32'd0);
  endtask

  // FWFT pop lands just after the edge that consumed the head word
  always @(posedge clk) begin
    cyc++;
    if (out_seq_re) begin
      #1;
      void'(fifo_q.pop_front());
      refresh();
    end
  end

  always @(negedge clk) begin
    if (out_seq_re) begin
      pops++;
      pop_cyc = cyc;
      if (s_cmd == CMD_FLUSH) flpop_cyc = cyc;
    end
    if (in_seq_we) begin
      pushes++;
      we_cyc = cyc;
      if (exp_q.size() == 0) check("unexpected_push", 32'd1, 32'd0);
      else check("tdo_byte", 32'(in_seq_tdo), 32'(exp_q.pop_front()));
    end
    if (TCK && !prev_tck) begin
      if (pulses < 8) begin
        tms_acc[pulses[2:0]] = TMS;
        tdi_acc[pulses[2:0]] = TDI;
      end
      pulses++;
    end
    if (in_seq_flushed && !prev_fl) fl_cyc = cyc;
    prev_tck = TCK;
    prev_fl  = in_seq_flushed;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p;
    int bad;
    refresh();

    repeat (3) @(negedge clk);
    check("rst_tck", 32'(TCK), 32'd0);
    check("rst_tms", 32'(TMS), 32'd1);
    check("rst_tdi", 32'(TDI), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flushed", 32'(in_seq_flushed), 32'd0);
    check("rst_tdo", 32'(in_seq_tdo), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_no_pop", 32'(pops), 32'd0);

    // full 8-bit word, TDO looped back from TDI
    tdo_tie = 1'b1;
    pulses = 0;
    p = pushes;
    send(CMD_WR, 3'd0, 8'hFF, 8'h3C, 8'hA5);
    exp_q.push_back(8'h3C);
    wait_idle(400);
    check("w8_pulses", 32'(pulses), 32'd8);
    check("w8_tms_seq", 32'(tms_acc), 32'hA5);
    check("w8_tdi_seq", 32'(tdi_acc), 32'h3C);
    check("w8_pushes", 32'(pushes - p), 32'd1);
    check("w8_latency", 32'(we_cyc - pop_cyc), 32'(16 * TCK_DIV + 1));

    // 3-bit write, no read, then flush
    pulses = 0;
    tdi_acc = 8'd0;
    p = pushes;
    send(CMD_WR, 3'd3, 8'h00, 8'h05, 8'h00);
    send(CMD_FLUSH, 3'd0, 8'h00, 8'h00, 8'h00);
    wait_idle(400);
    check("w3_pulses", 32'(pulses), 32'd3);
    check("w3_tdi_seq", 32'(tdi_acc), 32'h05);
    check("w3_no_push", 32'(pushes - p), 32'd0);
    check("flush_set", 32'(in_seq_flushed), 32'd1);
    check("flush_lat", 32'(fl_cyc - flpop_cyc), 32'd1);

    // 5-bit read held off by a full in_seq
    tdo_tie = 1'b0;
    tdo_val = 1'b1;
    in_seq_full = 1'b1;
    pulses = 0;
    p = pushes;
    send(CMD_WR, 3'd5, 8'hFF, 8'h00, 8'h00);
    send(CMD_EXECUTE, 3'd0, 8'h00, 8'h00, 8'h00);
    exp_q.push_back(8'h1F);
    wait_pulses(5, 300);
    while (TCK) @(negedge clk);
    p = pops;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (TCK || !busy || in_seq_we || out_seq_re) bad++;
    end
    check("full_hold", 32'(bad), 32'd0);
    check("full_no_pop", 32'(pops - p), 32'd0);
    in_seq_full = 1'b0;
    wait_idle(400);
    check("w5_pulses", 32'(pulses), 32'd5);
    check("w5_pushes", 32'(pushes - p + pops - pops), 32'(pushes - p));

    // discarded commands keep flushed; next WR clears it
    pulses = 0;
    p = pops;
    send(CMD_FLUSH, 3'd0, 8'h00, 8'h00, 8'h00);
    send(CMD_EXECUTE, 3'd0, 8'h00, 8'h00, 8'h00);
    send(CMD_STORE_SEQ, 3'd0, 8'h00, 8'h00, 8'h00);
    wait_idle(100);
    check("disc_pops", 32'(pops - p), 32'd3);
    check("disc_no_tck", 32'(pulses), 32'd0);
    check("disc_flushed", 32'(in_seq_flushed), 32'd1);
    send(CMD_WR, 3'd1, 8'h00, 8'h01, 8'h01);
    wait_idle(100);
    check("wr_clr_flush", 32'(in_seq_flushed), 32'd0);
    check("w1_pulses", 32'(pulses), 32'd1);

    // abort mid-shift at bit 4
    tdo_tie = 1'b1;
    pulses = 0;
    p = pushes;
    send(CMD_WR, 3'd0, 8'hFF, 8'hAA, 8'h0F);
    wait_pulses(5, 300);
    seq_rst = 1'b1;
    @(negedge clk);
    seq_rst = 1'b0;
    check("abort_tck", 32'(TCK), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_tms", 32'(TMS), 32'd1);
    check("abort_flushed", 32'(in_seq_flushed), 32'd0);
    repeat (30) @(negedge clk);
    check("abort_no_push", 32'(pushes - p), 32'd0);
    check("abort_pulses", 32'(pulses), 32'd5);

    pulses = 0;
    send(CMD_WR, 3'd2, 8'h01, 8'h02, 8'h00);
    exp_q.push_back(8'h02);
    wait_idle(200);
    check("post_pulses", 32'(pulses), 32'd2);
    check("post_pushes", 32'(pushes - p), 32'd1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
